// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
package div_pkg;

  // Default datapath width and the iteration counter width it needs
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  // Quotient reported for a divide by zero
  localparam logic [DIV_WIDTH-1:0] DZ_QUOT = '1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nxt,
  output logic             q_bit
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] t;

  // R never exceeds D, so r[WIDTH] is always 0 and the guard bit of this
  // subtract behaves exactly as the sign of a WIDTH+1-bit trial difference.
  always_comb begin
    sh    = {r, q_msb};
    t     = sh - {2'b00, d};
    q_bit = ~t[WIDTH+1];
    r_nxt = q_bit ? t[WIDTH:0] : sh[WIDTH:0];
  end

endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle radix-2 restoring divider: rA / rB -> rLO (quotient), rHI (remainder).
// One quotient bit per clock. Build with DIV_SIGNED_EN defined for two's
// complement operands (truncating toward zero); default build is unsigned.
module div_seq_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] rA,
  input  logic [WIDTH-1:0] rB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rLO,
  output logic [WIDTH-1:0] rHI,
  output logic             divZero
);

  localparam int              CW   = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DZ_Q = {WIDTH{DZ_QUOT[0]}};

  div_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] q, d;
  logic [WIDTH:0]   r, r_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_res, r_res;
  logic             b_zero;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
`endif

  assign b_zero = (b_reg == '0);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Operand magnitudes and signed result correction
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_mag = a_reg[WIDTH-1] ? -a_reg : a_reg;
    b_mag = b_reg[WIDTH-1] ? -b_reg : b_reg;
    q_res = neg_q ? -q : q;
    r_res = neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
`else
    a_mag = a_reg;
    b_mag = b_reg;
    q_res = q;
    r_res = r[WIDTH-1:0];
`endif
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r),
    .q_msb (q[WIDTH-1]),
    .d     (d),
    .r_nxt (r_nxt),
    .q_bit (q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a zero divisor skips the iteration phase
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = b_zero ? FIX : ITER;
      ITER:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration registers, result registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      q       <= '0;
      d       <= '0;
      r       <= '0;
      rLO     <= '0;
      rHI     <= '0;
      divZero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= rA;
            b_reg <= rB;
          end
        end
        PREP: begin
          r   <= '0;
          q   <= a_mag;
          d   <= b_mag;
          cnt <= '0;
`ifdef DIV_SIGNED_EN
          neg_q <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          neg_r <= a_reg[WIDTH-1];
`endif
        end
        ITER: begin
          r   <= r_nxt;
          q   <= {q[WIDTH-2:0], q_bit};
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        FIX: begin
          if (b_zero) begin
            rLO     <= DZ_Q;
            rHI     <= a_reg;
            divZero <= 1'b1;
          end else begin
            rLO     <= q_res;
            rHI     <= r_res;
            divZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Directed self-checking bench for div_seq_32 (both DIV_SIGNED_EN builds).
module tb_div_seq_32;

  logic        clk, clr, start;
  logic [31:0] rA, rB;
  logic        busy, done, divZero;
  logic [31:0] rLO, rHI;

  int checks   = 0;
  int failures = 0;

  div_seq_32 dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .rA      (rA),
    .rB      (rB),
    .busy    (busy),
    .done    (done),
    .rLO     (rLO),
    .rHI     (rHI),
    .divZero (divZero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch a divide, optionally poke a second start at edge 'poke', wait for
  // done (bounded), then check latency, results and the busy fall.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input int poke, input int exp_lat,
                    input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                    input logic exp_dz);
    int lat;
    rA = a; rB = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 60; e++) begin
      if (done) begin lat = e; break; end
      if (poke != 0 && e == poke - 1) begin rA = 32'd77; rB = 32'd3; start = 1'b1; end
      @(posedge clk); #1;
      if (poke != 0 && e == poke - 1) start = 1'b0;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rLO"}, rLO, exp_lo);
    chk({tag, ".rHI"}, rHI, exp_hi);
    chk({tag, ".divZero"}, {31'd0, divZero}, {31'd0, exp_dz});
    chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; rA = '0; rB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.rLO", rLO, 32'd0);
    chk("reset.rHI", rHI, 32'd0);
    chk("reset.divZero", {31'd0, divZero}, 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;

    op("basic_100_7", 32'd100, 32'd7, 0, 35, 32'd14, 32'd2, 1'b0);
`ifdef DIV_SIGNED_EN
    op("neg100_7", 32'hFFFF_FF9C, 32'd7, 0, 35, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    op("m1_2", 32'hFFFF_FFFF, 32'd2, 0, 35, 32'd0, 32'hFFFF_FFFF, 1'b0);
    op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0, 35, 32'h8000_0000, 32'd0, 1'b0);
`else
    op("neg100_7", 32'hFFFF_FF9C, 32'd7, 0, 35, 32'h2492_4916, 32'd2, 1'b0);
    op("m1_2", 32'hFFFF_FFFF, 32'd2, 0, 35, 32'h7FFF_FFFF, 32'd1, 1'b0);
    op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0, 35, 32'd0, 32'h8000_0000, 1'b0);
`endif
    op("divzero", 32'h0000_1234, 32'd0, 0, 3, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    op("small_5_9", 32'd5, 32'd9, 0, 35, 32'd0, 32'd5, 1'b0);

    // Second start mid-operation is ignored; then back-to-back start
    op("poke_1000_10", 32'd1000, 32'd10, 10, 35, 32'd100, 32'd0, 1'b0);
    op("b2b_50_6", 32'd50, 32'd6, 0, 35, 32'd8, 32'd2, 1'b0);

    // Clear in the middle of an operation
    rA = 32'd1000; rB = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk("midclr.busy", {31'd0, busy}, 32'd0);
    chk("midclr.done", {31'd0, done}, 32'd0);
    chk("midclr.rLO", rLO, 32'd0);
    chk("midclr.rHI", rHI, 32'd0);
    chk("midclr.divZero", {31'd0, divZero}, 32'd0);
    @(posedge clk); #1;
    chk("midclr.busy_held", {31'd0, busy}, 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("midclr.idle_after", {31'd0, busy}, 32'd0);
    op("after_clr_1000_7", 32'd1000, 32'd7, 0, 35, 32'd142, 32'd6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
